traffic_phase_arbiter: RTL
==========================

# traffic_phase_arbiter

Demand-actuated phase arbiter for the four-approach intersection. It grants green to one approach at a time among HighwayN, CityE, HighwayS and CityW, driven by vehicle-sensor requests. Service is round-robin, and approaches with no waiting traffic are skipped. Each approach's seven-segment light code (R/Y/G) is driven directly, along with a one-hot grant vector for downstream logic.

## Interface
- GREEN_MIN, 2: minimum green cycles per grant.
- GREEN_MAX, 6: maximum green cycles while another approach is waiting.
- YELLOW, 1: yellow cycles.
- ALLRED, 1: all-red clearance cycles.
- CNT_W, 4: phase counter width. Every timing parameter is in 1..2^CNT_W-1, and GREEN_MIN ≤ GREEN_MAX.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  sensor requests, level-sensitive, synchronous to clk. Bit 0=HighwayN, 1=CityE, 2=HighwayS, 3=CityW.
- HighwayN, CityE, HighwayS, CityW  out  7 each  light codes: RED=1110111, YELLOW=0110011, GREEN=1011111.
- grant  out  4  one-hot; the bit of the approach currently in GREEN, otherwise 0000.
- active  out  2  index of the approach last granted (current owner in GREEN/YELLOW).

## Operation
- States are IDLE, GREEN, YELLOW and ALLRED.
- Registers:
  - state
  - cnt (CNT_W bits)
  - cur (2 bits, owner)
  - last (2 bits, round-robin pointer)
- Round-robin pick: search last+1, last+2, last+3, last (mod 4); the first set req bit wins. Including `last` lets a sole requester be re-served.
- IDLE: all displays RED, grant 0000. If req≠0000, go to GREEN with cur=last=winner and cnt=1.
- GREEN: owner display GREEN, others RED, grant bit cur set.
  - cnt increments each cycle and saturates at GREEN_MAX.
  - other_req = |(req & ~onehot(cur)).
  - Exit to YELLOW at the edge where cnt ≥ GREEN_MIN && other_req && (!req[cur] || cnt ≥ GREEN_MAX).
  - Otherwise hold. With no other requester, green rests indefinitely.
  - On exit, load cnt=1.
- YELLOW: owner display YELLOW, others RED, grant 0000. After YELLOW cycles go to ALLRED with cnt=1.
- ALLRED: all RED, grant 0000. After ALLRED cycles, do a round-robin pick on the current req:
  - winner exists: go to GREEN with cur=last=winner, cnt=1;
  - req=0000: go to IDLE.
- The next owner is chosen only at ALLRED exit. req changes during YELLOW/ALLRED do not alter the sequence.
- Outputs are decoded from registered state only (Moore); there is no combinational path from req to outputs.
- An undefined state recovers to IDLE on the next edge.
- Two approaches are never GREEN or YELLOW simultaneously. Any green-to-green handover passes through YELLOW then ALLRED.

## Timing
- Reset (rst_n=0) takes effect immediately, independent of clk:
  - state=IDLE, cnt=0, cur=0, last=3;
  - all four displays RED (1110111), grant=0000, active=0.
- Reset mid-phase (including YELLOW) forces all RED immediately.
- After release, the first pick starts at HighwayN.
- Latency from IDLE with req asserted before edge k: GREEN visible after edge k (1 cycle).
- Green duration is exactly the cnt value at exit:
  - GREEN_MIN when the owner's req is low and another approach is waiting (gap-out);
  - GREEN_MAX when the owner keeps requesting against competition (max-out).
- YELLOW lasts exactly YELLOW cycles; ALLRED lasts exactly ALLRED cycles.
- The full handover green→next green is YELLOW+ALLRED cycles.
- Simultaneous requests are resolved purely by round-robin order; there is no fixed priority beyond the post-reset pointer.

## Test plan
- Reset, req=0000 for 10 cycles → all displays 1110111, grant 0000. Set req=0001 before edge k → after edge k HighwayN=1011111, grant=0001, active=0.
- req=0001 held for 30 cycles, no others → HighwayN stays GREEN the whole time, with no YELLOW.
- req=1111 held → HighwayN GREEN 6, YELLOW 1, ALLRED 1, then CityE GREEN 6, then HighwayS, then CityW, then HighwayN again. grant sequence: 0001, 0010, 0100, 1000, 0001.
- HighwayN green, then req=1000 from its 1st green cycle (own drops) → GREEN exactly 2 cycles, YELLOW, ALLRED, then CityW GREEN (CityE and HighwayS skipped), active=3.
- HighwayN green with req=0011; drop req to 0000 during YELLOW → ALLRED then IDLE all RED. Then req=0100 → HighwayS GREEN one cycle later.
- Assert rst_n=0 mid-YELLOW of CityE → all RED and grant 0000 without a clock edge. Release with req=1010 → CityE (bit 1) granted first.

Source files
------------

// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated, round-robin green-phase arbiter for a four-approach intersection.
// It steps through GREEN -> YELLOW -> ALLRED and skips approaches that have no waiting traffic.
module traffic_phase_arbiter #(
  parameter int GREEN_MIN = 2,
  parameter int GREEN_MAX = 6,
  parameter int YELLOW    = 1,
  parameter int ALLRED    = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [6:0] HighwayN,
  output logic [6:0] CityE,
  output logic [6:0] HighwayS,
  output logic [6:0] CityW,
  output logic [3:0] grant,
  output logic [1:0] active
);

  localparam logic [6:0] LIGHT_RED    = 7'b1110111;
  localparam logic [6:0] LIGHT_YELLOW = 7'b0110011;
  localparam logic [6:0] LIGHT_GREEN  = 7'b1011111;

  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_LEN = CNT_W'(YELLOW);
  localparam logic [CNT_W-1:0] A_LEN = CNT_W'(ALLRED);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW_S, ALLRED_S} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cur, cur_nxt;
  logic [1:0]       last, last_nxt;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic [3:0] cur_oh;
  logic       other_req;
  logic [6:0] lights [4];

  assign cur_oh    = 4'b0001 << cur;
  assign other_req = |(req & ~cur_oh);

  // Search from farthest (last) to nearest (last+1), so the nearest requester is written last and wins.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= 2'd0;
      last  <= 2'd3;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cur   <= cur_nxt;
      last  <= last_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GREEN;
          cur_nxt   = winner;
          last_nxt  = winner;
          cnt_nxt   = ONE;
        end
      end
      GREEN: begin
        if (cnt >= G_MIN && other_req && (!req[cur] || cnt >= G_MAX)) begin
          state_nxt = YELLOW_S;
          cnt_nxt   = ONE;
        end else if (cnt < G_MAX) begin
          cnt_nxt = cnt + ONE;
        end
      end
      YELLOW_S: begin
        if (cnt >= Y_LEN) begin
          state_nxt = ALLRED_S;
          cnt_nxt   = ONE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      ALLRED_S: begin
        if (cnt >= A_LEN) begin
          if (found) begin
            state_nxt = GREEN;
            cur_nxt   = winner;
            last_nxt  = winner;
            cnt_nxt   = ONE;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Moore outputs: only registered state feeds the displays and the grant vector.
  always_comb begin
    for (int i = 0; i < 4; i++) lights[i] = LIGHT_RED;
    grant = 4'b0000;
    case (state)
      GREEN: begin
        lights[cur] = LIGHT_GREEN;
        grant       = cur_oh;
      end
      YELLOW_S: lights[cur] = LIGHT_YELLOW;
      default: ;
    endcase
  end

  assign HighwayN = lights[0];
  assign CityE    = lights[1];
  assign HighwayS = lights[2];
  assign CityW    = lights[3];
  assign active   = cur;

endmodule
